mem_rd_arbiter: RTL and testbench
=================================

MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, memory read address width.
REQ-002 SHALL have parameter DATA_W, 32, width of one burst data beat.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port from_icache_rd_req_valid  in  1  I-cache read request valid.
REQ-006 SHALL have port from_icache_rd_req_addr  in  ADDR_W  I-cache request address, 32-byte aligned.
REQ-007 SHALL have port to_icache_rd_req_ready  out  1  I-cache request accepted.
REQ-008 SHALL have port to_icache_rd_rsp_valid  out  1  beat valid to I-cache.
REQ-009 SHALL have port to_icache_rd_rsp_data  out  DATA_W  beat data to I-cache.
REQ-010 SHALL have port to_icache_rd_rsp_last  out  1  last beat to I-cache.
REQ-011 SHALL have port from_icache_rd_rsp_ready  in  1  I-cache accepts beat.
REQ-012 SHALL have ports from_dcache_rd_req_valid, from_dcache_rd_req_addr, to_dcache_rd_req_ready, to_dcache_rd_rsp_valid, to_dcache_rd_rsp_data, to_dcache_rd_rsp_last and from_dcache_rd_rsp_ready, each with the same direction, width and meaning as its I-cache counterpart, for the D-cache.
REQ-013 SHALL have port to_mem_rd_req_valid  out  1  request valid to memory.
REQ-014 SHALL have port to_mem_rd_req_addr  out  ADDR_W  granted request address.
REQ-015 SHALL have port from_mem_rd_req_ready  in  1  memory accepts request.
REQ-016 SHALL have port from_mem_rd_rsp_valid  in  1  memory beat valid.
REQ-017 SHALL have port from_mem_rd_rsp_data  in  DATA_W  memory beat data.
REQ-018 SHALL have port from_mem_rd_rsp_last  in  1  last beat of burst.
REQ-019 SHALL have port to_mem_rd_rsp_ready  out  1  arbiter accepts beat.

Function
REQ-020 SHALL implement one-hot FSM with states S_IDLE, S_REQ and S_RECV.
REQ-021 In S_IDLE, any requester valid SHALL register grant owner and owner address, then move to S_REQ on the next cycle; request reaches memory 1 cycle after valid seen.
REQ-022 When both valids are high in S_IDLE, the arbiter SHALL grant the requester not granted last (round-robin on 1-bit last_grant, updated at each grant).
REQ-023 In S_REQ, to_mem_rd_req_valid SHALL be 1 and to_mem_rd_req_addr SHALL be the latched address; owner's rd_req_ready SHALL equal from_mem_rd_req_ready; on that handshake -> S_RECV.
REQ-024 In S_RECV, memory beat valid, data and last SHALL route to the owner only; to_mem_rd_rsp_ready SHALL equal the owner's rsp_ready.
REQ-025 In S_RECV, a beat with valid&ready&last SHALL return to S_IDLE; a new grant is possible only from the following cycle.
REQ-026 Non-owner rsp_valid, rsp_last and req_ready SHALL be 0 in every state; rsp_data to a non-owner SHALL be 0.
REQ-027 Request ready to both caches SHALL be 0 in S_IDLE and S_RECV.
REQ-028 The arbiter SHALL NOT grant a new request while a burst is outstanding; requesters hold valid and address until ready.
REQ-029 A memory beat arriving in S_IDLE or S_REQ SHALL be ignored, with to_mem_rd_rsp_ready=0.
REQ-030 A requester deasserting valid in S_REQ SHALL NOT cancel the latched request.

Reset
REQ-031 rst SHALL force S_IDLE, clear owner, latched address and outputs to 0, and set last_grant=ICACHE so the first tie goes to D-cache.
REQ-032 rst mid-burst SHALL abandon the burst; later beats are ignored per REQ-029.

Structure
REQ-033 A shared package SHALL hold state encodings and requester IDs (REQ_ICACHE=0, REQ_DCACHE=1).
REQ-034 A combinational sub-module mem_rd_rr_pick (two valids plus last_grant -> grant) SHALL implement the arbitration choice.

Verification
REQ-035 Lone I-cache request addr 0x1000, mem ready immediately, 8 beats 0..7 with last on beat 7 -> I-cache gets 8 beats, D-cache rsp_valid stays 0, back to S_IDLE.
REQ-036 Both valid after reset (I 0x2000, D 0x3000) -> D granted first with mem addr 0x3000, then I with 0x2000 after D's last beat.
REQ-037 D-cache rsp_ready low for 3 cycles mid-burst -> to_mem_rd_rsp_ready low for those cycles, no beat lost or duplicated.
REQ-038 D-cache valid rising during I-cache burst -> no memory request until I-cache last beat, D granted next.
REQ-039 rst asserted in S_RECV after beat 3 -> all outputs 0 next cycle, remaining beats ignored, new request serviced normally.

Source files
------------

// File: rtl/mem_rd_arbiter_pkg.sv
// mem_rd_arbiter_pkg: shared state encodings and requester IDs for the memory read arbiter
package mem_rd_arbiter_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_REQ  = 3'b010,
    S_RECV = 3'b100
  } state_t;
  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;
endpackage

// File: rtl/mem_rd_rr_pick.sv
// mem_rd_rr_pick: two-way round-robin choice between I-cache and D-cache requests
module mem_rd_rr_pick
  import mem_rd_arbiter_pkg::*;
(
  input  logic icache_valid,
  input  logic dcache_valid,
  input  logic last_grant,
  output logic any,
  output logic grant
);
  always_comb begin
    any   = icache_valid | dcache_valid;
    grant = (icache_valid & dcache_valid) ? ~last_grant : (dcache_valid ? REQ_DCACHE : REQ_ICACHE);
  end
endmodule

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: shares one burst-read memory port between I-cache and D-cache, one burst at a time
module mem_rd_arbiter
  import mem_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              from_icache_rd_req_valid,
  input  logic [ADDR_W-1:0] from_icache_rd_req_addr,
  output logic              to_icache_rd_req_ready,
  output logic              to_icache_rd_rsp_valid,
  output logic [DATA_W-1:0] to_icache_rd_rsp_data,
  output logic              to_icache_rd_rsp_last,
  input  logic              from_icache_rd_rsp_ready,
  input  logic              from_dcache_rd_req_valid,
  input  logic [ADDR_W-1:0] from_dcache_rd_req_addr,
  output logic              to_dcache_rd_req_ready,
  output logic              to_dcache_rd_rsp_valid,
  output logic [DATA_W-1:0] to_dcache_rd_rsp_data,
  output logic              to_dcache_rd_rsp_last,
  input  logic              from_dcache_rd_rsp_ready,
  output logic              to_mem_rd_req_valid,
  output logic [ADDR_W-1:0] to_mem_rd_req_addr,
  input  logic              from_mem_rd_req_ready,
  input  logic              from_mem_rd_rsp_valid,
  input  logic [DATA_W-1:0] from_mem_rd_rsp_data,
  input  logic              from_mem_rd_rsp_last,
  output logic              to_mem_rd_rsp_ready
);
  state_t            state, state_nxt;
  logic              owner, last_grant, grant, any;
  logic [ADDR_W-1:0] addr;
  logic              own_i, own_d, in_req, in_recv, owner_rsp_ready;

  mem_rd_rr_pick u_pick (
    .icache_valid(from_icache_rd_req_valid),
    .dcache_valid(from_dcache_rd_req_valid),
    .last_grant  (last_grant),
    .any         (any),
    .grant       (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= REQ_ICACHE;
      addr       <= '0;
      last_grant <= REQ_ICACHE;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && any) begin
        owner      <= grant;
        addr       <= (grant == REQ_DCACHE) ? from_dcache_rd_req_addr : from_icache_rd_req_addr;
        last_grant <= grant;
      end
    end
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = any ? S_REQ : S_IDLE;
      S_REQ:   state_nxt = from_mem_rd_req_ready ? S_RECV : S_REQ;
      S_RECV:  state_nxt = (from_mem_rd_rsp_valid & owner_rsp_ready & from_mem_rd_rsp_last) ? S_IDLE : S_RECV;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Everything towards the caches is gated by ownership so the non-owner sees all zeros.
  always_comb begin
    own_i                  = owner == REQ_ICACHE;
    own_d                  = owner == REQ_DCACHE;
    in_req                 = state == S_REQ;
    in_recv                = state == S_RECV;
    owner_rsp_ready        = own_d ? from_dcache_rd_rsp_ready : from_icache_rd_rsp_ready;
    to_mem_rd_req_valid    = in_req;
    to_mem_rd_req_addr     = in_req ? addr : '0;
    to_mem_rd_rsp_ready    = in_recv & owner_rsp_ready;
    to_icache_rd_req_ready = in_req & own_i & from_mem_rd_req_ready;
    to_dcache_rd_req_ready = in_req & own_d & from_mem_rd_req_ready;
    to_icache_rd_rsp_valid = in_recv & own_i & from_mem_rd_rsp_valid;
    to_dcache_rd_rsp_valid = in_recv & own_d & from_mem_rd_rsp_valid;
    to_icache_rd_rsp_last  = in_recv & own_i & from_mem_rd_rsp_last;
    to_dcache_rd_rsp_last  = in_recv & own_d & from_mem_rd_rsp_last;
    to_icache_rd_rsp_data  = (in_recv & own_i) ? from_mem_rd_rsp_data : '0;
    to_dcache_rd_rsp_data  = (in_recv & own_d) ? from_mem_rd_rsp_data : '0;
  end
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb_mem_rd_arbiter: directed scenario tests for the I/D-cache memory read arbiter
module tb_mem_rd_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        from_icache_rd_req_valid, to_icache_rd_req_ready, to_icache_rd_rsp_valid, to_icache_rd_rsp_last, from_icache_rd_rsp_ready;
  logic [31:0] from_icache_rd_req_addr, to_icache_rd_rsp_data;
  logic        from_dcache_rd_req_valid, to_dcache_rd_req_ready, to_dcache_rd_rsp_valid, to_dcache_rd_rsp_last, from_dcache_rd_rsp_ready;
  logic [31:0] from_dcache_rd_req_addr, to_dcache_rd_rsp_data;
  logic        to_mem_rd_req_valid, from_mem_rd_req_ready, from_mem_rd_rsp_valid, from_mem_rd_rsp_last, to_mem_rd_rsp_ready;
  logic [31:0] to_mem_rd_req_addr, from_mem_rd_rsp_data;
  int          errors = 0;
  int          checks = 0;

  mem_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .from_icache_rd_req_valid(from_icache_rd_req_valid), .from_icache_rd_req_addr(from_icache_rd_req_addr),
    .to_icache_rd_req_ready(to_icache_rd_req_ready), .to_icache_rd_rsp_valid(to_icache_rd_rsp_valid),
    .to_icache_rd_rsp_data(to_icache_rd_rsp_data), .to_icache_rd_rsp_last(to_icache_rd_rsp_last),
    .from_icache_rd_rsp_ready(from_icache_rd_rsp_ready),
    .from_dcache_rd_req_valid(from_dcache_rd_req_valid), .from_dcache_rd_req_addr(from_dcache_rd_req_addr),
    .to_dcache_rd_req_ready(to_dcache_rd_req_ready), .to_dcache_rd_rsp_valid(to_dcache_rd_rsp_valid),
    .to_dcache_rd_rsp_data(to_dcache_rd_rsp_data), .to_dcache_rd_rsp_last(to_dcache_rd_rsp_last),
    .from_dcache_rd_rsp_ready(from_dcache_rd_rsp_ready),
    .to_mem_rd_req_valid(to_mem_rd_req_valid), .to_mem_rd_req_addr(to_mem_rd_req_addr),
    .from_mem_rd_req_ready(from_mem_rd_req_ready), .from_mem_rd_rsp_valid(from_mem_rd_rsp_valid),
    .from_mem_rd_rsp_data(from_mem_rd_rsp_data), .from_mem_rd_rsp_last(from_mem_rd_rsp_last),
    .to_mem_rd_rsp_ready(to_mem_rd_rsp_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs;
    from_icache_rd_req_valid = 0; from_icache_rd_req_addr = '0; from_icache_rd_rsp_ready = 1;
    from_dcache_rd_req_valid = 0; from_dcache_rd_req_addr = '0; from_dcache_rd_rsp_ready = 1;
    from_mem_rd_req_ready = 0; from_mem_rd_rsp_valid = 0; from_mem_rd_rsp_data = '0; from_mem_rd_rsp_last = 0;
  endtask

  task automatic test_reset;
    quiet_inputs();
    rst = 1;
    step(); step();
    rst = 0;
    from_mem_rd_rsp_valid = 1; from_mem_rd_rsp_data = 32'hdead_beef; from_mem_rd_rsp_last = 1;
    #1;
    checks++;
    if ({to_icache_rd_req_ready, to_icache_rd_rsp_valid, to_icache_rd_rsp_last, to_dcache_rd_req_ready,
         to_dcache_rd_rsp_valid, to_dcache_rd_rsp_last, to_mem_rd_req_valid, to_mem_rd_rsp_ready} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl: outputs not all zero after reset");
    end
    checks++;
    if (to_mem_rd_req_addr !== 32'h0 || to_icache_rd_rsp_data !== 32'h0 || to_dcache_rd_rsp_data !== 32'h0) begin
      errors++; $display("FAIL reset_data: addr=%h idata=%h ddata=%h required 0", to_mem_rd_req_addr, to_icache_rd_rsp_data, to_dcache_rd_rsp_data);
    end
    step();
    checks++;
    if (to_mem_rd_req_valid !== 1'b0 || to_mem_rd_rsp_ready !== 1'b0) begin
      errors++; $display("FAIL idle_beat_ignored: req_valid=%b rsp_ready=%b required 0 0", to_mem_rd_req_valid, to_mem_rd_rsp_ready);
    end
    quiet_inputs();
  endtask

  task automatic test_lone_icache;
    from_icache_rd_req_valid = 1; from_icache_rd_req_addr = 32'h1000; from_mem_rd_req_ready = 1;
    #1;
    checks++;
    if (to_mem_rd_req_valid !== 1'b0 || to_icache_rd_req_ready !== 1'b0) begin
      errors++; $display("FAIL lone_idle_latency: req_valid=%b ready=%b required 0 0", to_mem_rd_req_valid, to_icache_rd_req_ready);
    end
    step();
    checks++;
    if (to_mem_rd_req_valid !== 1'b1 || to_mem_rd_req_addr !== 32'h1000 || to_icache_rd_req_ready !== 1'b1 || to_dcache_rd_req_ready !== 1'b0) begin
      errors++; $display("FAIL lone_req: valid=%b addr=%h iready=%b dready=%b required 1 1000 1 0",
                         to_mem_rd_req_valid, to_mem_rd_req_addr, to_icache_rd_req_ready, to_dcache_rd_req_ready);
    end
    step();
    from_icache_rd_req_valid = 0; from_mem_rd_req_ready = 0;
    for (int k = 0; k < 8; k++) begin
      from_mem_rd_rsp_valid = 1; from_mem_rd_rsp_data = k; from_mem_rd_rsp_last = (k == 7);
      #1;
      checks++;
      if (to_icache_rd_rsp_valid !== 1'b1 || to_icache_rd_rsp_data !== k || to_icache_rd_rsp_last !== (k == 7)) begin
        errors++; $display("FAIL lone_beat%0d: valid=%b data=%h last=%b", k, to_icache_rd_rsp_valid, to_icache_rd_rsp_data, to_icache_rd_rsp_last);
      end
      checks++;
      if (to_dcache_rd_rsp_valid !== 1'b0 || to_dcache_rd_rsp_data !== 32'h0 || to_mem_rd_rsp_ready !== 1'b1) begin
        errors++; $display("FAIL lone_route%0d: dvalid=%b ddata=%h mem_ready=%b required 0 0 1", k, to_dcache_rd_rsp_valid, to_dcache_rd_rsp_data, to_mem_rd_rsp_ready);
      end
      step();
    end
    from_mem_rd_rsp_data = 32'h99; from_mem_rd_rsp_last = 0;
    #1;
    checks++;
    if (to_mem_rd_rsp_ready !== 1'b0 || to_icache_rd_rsp_valid !== 1'b0 || to_mem_rd_req_valid !== 1'b0) begin
      errors++; $display("FAIL lone_back_idle: rsp_ready=%b ivalid=%b req_valid=%b required 0 0 0", to_mem_rd_rsp_ready, to_icache_rd_rsp_valid, to_mem_rd_req_valid);
    end
    quiet_inputs();
  endtask

  task automatic test_back_to_back;
    rst = 1; step(); rst = 0;
    from_icache_rd_req_valid = 1; from_icache_rd_req_addr = 32'h2000;
    from_dcache_rd_req_valid = 1; from_dcache_rd_req_addr = 32'h3000; from_mem_rd_req_ready = 1;
    step();
    checks++;
    if (to_mem_rd_req_addr !== 32'h3000 || to_dcache_rd_req_ready !== 1'b1 || to_icache_rd_req_ready !== 1'b0) begin
      errors++; $display("FAIL tie_first_d: addr=%h dready=%b iready=%b required 3000 1 0", to_mem_rd_req_addr, to_dcache_rd_req_ready, to_icache_rd_req_ready);
    end
    step();
    from_dcache_rd_req_valid = 0; from_mem_rd_req_ready = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin from_dcache_rd_req_valid = 1; from_dcache_rd_req_addr = 32'h3100; end
      from_mem_rd_rsp_valid = 1; from_mem_rd_rsp_data = 32'h300 + k; from_mem_rd_rsp_last = (k == 3);
      #1;
      checks++;
      if (to_dcache_rd_rsp_valid !== 1'b1 || to_dcache_rd_rsp_data !== 32'h300 + k || to_icache_rd_rsp_valid !== 1'b0 || to_icache_rd_req_ready !== 1'b0) begin
        errors++; $display("FAIL d_burst%0d: dvalid=%b ddata=%h ivalid=%b iready=%b", k, to_dcache_rd_rsp_valid, to_dcache_rd_rsp_data, to_icache_rd_rsp_valid, to_icache_rd_req_ready);
      end
      step();
    end
    from_mem_rd_rsp_valid = 0; from_mem_rd_rsp_last = 0; from_mem_rd_req_ready = 1;
    step();
    checks++;
    if (to_mem_rd_req_addr !== 32'h2000 || to_icache_rd_req_ready !== 1'b1 || to_dcache_rd_req_ready !== 1'b0) begin
      errors++; $display("FAIL tie_second_i: addr=%h iready=%b dready=%b required 2000 1 0", to_mem_rd_req_addr, to_icache_rd_req_ready, to_dcache_rd_req_ready);
    end
    step();
    from_icache_rd_req_valid = 0;
    from_mem_rd_rsp_valid = 1; from_mem_rd_rsp_data = 32'h200; from_mem_rd_rsp_last = 1;
    #1;
    checks++;
    if (to_icache_rd_rsp_valid !== 1'b1 || to_icache_rd_rsp_data !== 32'h200 || to_icache_rd_rsp_last !== 1'b1 || to_dcache_rd_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL i_beat: ivalid=%b idata=%h ilast=%b dvalid=%b", to_icache_rd_rsp_valid, to_icache_rd_rsp_data, to_icache_rd_rsp_last, to_dcache_rd_rsp_valid);
    end
    step();
    from_mem_rd_rsp_valid = 0; from_mem_rd_rsp_last = 0;
    step();
    checks++;
    if (to_mem_rd_req_addr !== 32'h3100 || to_dcache_rd_req_ready !== 1'b1) begin
      errors++; $display("FAIL d_after_i: addr=%h dready=%b required 3100 1", to_mem_rd_req_addr, to_dcache_rd_req_ready);
    end
    step();
    from_dcache_rd_req_valid = 0;
    from_mem_rd_rsp_valid = 1; from_mem_rd_rsp_data = 32'h310; from_mem_rd_rsp_last = 1;
    step();
    quiet_inputs();
  endtask

  task automatic test_backpressure;
    logic rdy;
    int   idx;
    from_dcache_rd_req_valid = 1; from_dcache_rd_req_addr = 32'h4000; from_mem_rd_req_ready = 1;
    step(); step();
    from_dcache_rd_req_valid = 0; from_mem_rd_req_ready = 0;
    idx = 0;
    for (int c = 0; c < 9; c++) begin
      rdy = !(c >= 2 && c <= 4);
      from_dcache_rd_rsp_ready = rdy;
      from_mem_rd_rsp_valid = 1; from_mem_rd_rsp_data = 32'h40 + idx; from_mem_rd_rsp_last = (idx == 5);
      #1;
      checks++;
      if (to_mem_rd_rsp_ready !== rdy) begin
        errors++; $display("FAIL bp_ready_c%0d: mem_rsp_ready=%b required %b", c, to_mem_rd_rsp_ready, rdy);
      end
      checks++;
      if (to_dcache_rd_rsp_valid !== 1'b1 || to_dcache_rd_rsp_data !== 32'h40 + idx) begin
        errors++; $display("FAIL bp_beat_c%0d: dvalid=%b ddata=%h required 1 %h", c, to_dcache_rd_rsp_valid, to_dcache_rd_rsp_data, 32'h40 + idx);
      end
      if (rdy) idx++;
      step();
    end
    from_mem_rd_rsp_data = 32'h77; from_mem_rd_rsp_last = 0;
    #1;
    checks++;
    if (to_mem_rd_rsp_ready !== 1'b0 || to_dcache_rd_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_end_idle: mem_rsp_ready=%b dvalid=%b required 0 0", to_mem_rd_rsp_ready, to_dcache_rd_rsp_valid);
    end
    quiet_inputs();
  endtask

  task automatic test_block_during_burst;
    from_icache_rd_req_valid = 1; from_icache_rd_req_addr = 32'h5000; from_mem_rd_req_ready = 1;
    step(); step();
    from_icache_rd_req_valid = 0; from_mem_rd_req_ready = 1;
    from_dcache_rd_req_valid = 1; from_dcache_rd_req_addr = 32'h6000;
    for (int k = 0; k < 3; k++) begin
      from_mem_rd_rsp_valid = 1; from_mem_rd_rsp_data = 32'h50 + k; from_mem_rd_rsp_last = (k == 2);
      #1;
      checks++;
      if (to_mem_rd_req_valid !== 1'b0 || to_dcache_rd_req_ready !== 1'b0 || to_icache_rd_rsp_data !== 32'h50 + k) begin
        errors++; $display("FAIL blocked%0d: req_valid=%b dready=%b idata=%h", k, to_mem_rd_req_valid, to_dcache_rd_req_ready, to_icache_rd_rsp_data);
      end
      step();
    end
    from_mem_rd_rsp_valid = 0; from_mem_rd_rsp_last = 0;
    #1;
    checks++;
    if (to_mem_rd_req_valid !== 1'b0) begin
      errors++; $display("FAIL blocked_idle: req_valid=%b required 0", to_mem_rd_req_valid);
    end
    step();
    checks++;
    if (to_mem_rd_req_valid !== 1'b1 || to_mem_rd_req_addr !== 32'h6000 || to_dcache_rd_req_ready !== 1'b1) begin
      errors++; $display("FAIL blocked_then_d: valid=%b addr=%h dready=%b required 1 6000 1", to_mem_rd_req_valid, to_mem_rd_req_addr, to_dcache_rd_req_ready);
    end
    step();
    from_dcache_rd_req_valid = 0; from_mem_rd_req_ready = 0;
    from_mem_rd_rsp_valid = 1; from_mem_rd_rsp_data = 32'h60; from_mem_rd_rsp_last = 1;
    #1;
    checks++;
    if (to_dcache_rd_rsp_valid !== 1'b1 || to_dcache_rd_rsp_last !== 1'b1 || to_icache_rd_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL blocked_d_beat: dvalid=%b dlast=%b ivalid=%b required 1 1 0", to_dcache_rd_rsp_valid, to_dcache_rd_rsp_last, to_icache_rd_rsp_valid);
    end
    step();
    quiet_inputs();
  endtask

  task automatic test_reset_mid_burst;
    from_dcache_rd_req_valid = 1; from_dcache_rd_req_addr = 32'h7000; from_mem_rd_req_ready = 1;
    step(); step();
    from_dcache_rd_req_valid = 0; from_mem_rd_req_ready = 0;
    for (int k = 0; k < 4; k++) begin
      from_mem_rd_rsp_valid = 1; from_mem_rd_rsp_data = 32'h70 + k; from_mem_rd_rsp_last = 0;
      step();
    end
    from_mem_rd_rsp_data = 32'h74; rst = 1;
    step();
    rst = 0;
    #1;
    checks++;
    if ({to_icache_rd_req_ready, to_icache_rd_rsp_valid, to_icache_rd_rsp_last, to_dcache_rd_req_ready,
         to_dcache_rd_rsp_valid, to_dcache_rd_rsp_last, to_mem_rd_req_valid, to_mem_rd_rsp_ready} !== 8'h00
        || to_dcache_rd_rsp_data !== 32'h0 || to_mem_rd_req_addr !== 32'h0) begin
      errors++; $display("FAIL rst_mid_zero: dvalid=%b ddata=%h mem_rsp_ready=%b required all 0", to_dcache_rd_rsp_valid, to_dcache_rd_rsp_data, to_mem_rd_rsp_ready);
    end
    for (int k = 5; k < 8; k++) begin
      from_mem_rd_rsp_data = 32'h70 + k; from_mem_rd_rsp_last = (k == 7);
      #1;
      checks++;
      if (to_mem_rd_rsp_ready !== 1'b0 || to_dcache_rd_rsp_valid !== 1'b0) begin
        errors++; $display("FAIL rst_stale%0d: mem_rsp_ready=%b dvalid=%b required 0 0", k, to_mem_rd_rsp_ready, to_dcache_rd_rsp_valid);
      end
      step();
    end
    from_mem_rd_rsp_valid = 0; from_mem_rd_rsp_last = 0;
    from_icache_rd_req_valid = 1; from_icache_rd_req_addr = 32'h8000; from_mem_rd_req_ready = 1;
    step();
    checks++;
    if (to_mem_rd_req_addr !== 32'h8000 || to_icache_rd_req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_new_req: addr=%h iready=%b required 8000 1", to_mem_rd_req_addr, to_icache_rd_req_ready);
    end
    step();
    from_icache_rd_req_valid = 0; from_mem_rd_req_ready = 0;
    from_mem_rd_rsp_valid = 1; from_mem_rd_rsp_data = 32'h80; from_mem_rd_rsp_last = 1;
    #1;
    checks++;
    if (to_icache_rd_rsp_valid !== 1'b1 || to_icache_rd_rsp_data !== 32'h80 || to_mem_rd_rsp_ready !== 1'b1) begin
      errors++; $display("FAIL rst_new_beat: ivalid=%b idata=%h mem_rsp_ready=%b required 1 80 1", to_icache_rd_rsp_valid, to_icache_rd_rsp_data, to_mem_rd_rsp_ready);
    end
    step();
    from_mem_rd_rsp_last = 0;
    #1;
    checks++;
    if (to_mem_rd_rsp_ready !== 1'b0) begin
      errors++; $display("FAIL rst_new_done: mem_rsp_ready=%b required 0", to_mem_rd_rsp_ready);
    end
    quiet_inputs();
  endtask

  initial begin
    test_reset();
    test_lone_icache();
    test_back_to_back();
    test_backpressure();
    test_block_during_burst();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
